hex_rate_counter: RTL and testbench
===================================

Name: hex_rate_counter

Overview:
- Upstream source for the 7-segment hex decoder.
- Produces a 4-bit hex digit that steps 0..F (up or down) at a switch-selectable rate derived from the 50 MHz board clock.
- Supports enable, synchronous clear and parallel load.
- count[3:0] wires directly to the decoder's 4-bit digit input; tick and wrap are available for chaining further digits or LEDs.

Parameters:
- CLK_HZ, 50000000, board clock frequency; sets the 1 Hz reload value (benches use 4).
- DIV_WIDTH, 28, rate-divider width; must hold 4*CLK_HZ-1.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = divider runs and count may step; 0 = everything holds.
- rate_sel  input  2  00 every clock, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
- up_down  input  1  1 = increment, 0 = decrement.
- clear  input  1  synchronous clear of count and divider.
- load  input  1  synchronous parallel load.
- load_val  input  4  value loaded when load=1.
- count  output  4  current hex digit, registered; feeds the decoder.
- tick  output  1  registered one-cycle pulse, high in the cycle count shows a newly stepped value.
- wrap  output  1  registered one-cycle pulse, high with tick when the step wrapped (F->0 up, 0->F down).

Behaviour:
- Reload values:
  - R(00)=0
  - R(01)=CLK_HZ-1
  - R(10)=2*CLK_HZ-1
  - R(11)=4*CLK_HZ-1
- Reset (synchronous, active high) sets:
  - count=0, tick=0, wrap=0
  - divider=R(rate_sel)
  - rate_q=rate_sel (registered copy of rate_sel)
- Priority each edge: reset > clear > load > rate change > step > hold.
- Clear:
  - count=0, divider=R(rate_sel), tick=0, wrap=0.
  - Applies regardless of enable.
- Load:
  - count=load_val, divider=R(rate_sel), tick=0, wrap=0.
  - Applies regardless of enable.
- Rate change (rate_sel != rate_q):
  - divider=R(rate_sel), rate_q updated, no step, tick=0.
  - Stepping resumes from a full period of the new rate.
- Step condition: enable=1 and divider==0.
  - On that edge: count=count±1 modulo 16; divider=R(rate_sel); tick=1; wrap=1 iff the step wrapped.
- Enable=1, divider!=0: divider decrements by 1; tick=0, wrap=0.
- Enable=0: divider and count hold; tick=0, wrap=0. Re-enabling continues from the held divider value; the period is not restarted.
- Step period: exactly R+1 enabled cycles. Rate 00 steps every enabled cycle, so tick stays high continuously.
- tick and wrap never last longer than one cycle per step, and never fire on clear, load, reset or rate change.
- up_down is sampled on the stepping edge only; changing it mid-period takes effect at the next step.
- Divider arithmetic is unsigned DIV_WIDTH bits. R(11) must fit in DIV_WIDTH bits; overflow is a parameter error, not handled in RTL.
- Latency: count updates on the same edge the divider hits zero. There is no extra pipeline stage between divider and count.

Test Plan:
- Reset/hold, CLK_HZ=4, rate_sel=01, enable=1, hold reset 2 cycles then release -> count=0, tick=0 during reset; first tick 4 cycles after release with count=1; then tick every 4 cycles (count 2, 3, ...).
- Rate 00 wrap, enable=1, up_down=1 -> count 0,1,...,F,0 on consecutive cycles; tick constantly 1; wrap=1 only in the cycle count shows 0 after F. With up_down=0 from count=0 -> next count=F, wrap=1.
- Rate change, CLK_HZ=4, rate 01 running, switch rate_sel to 11 two cycles after a step -> no tick on the change edge; next tick exactly 16 cycles after the change edge; subsequent ticks every 16.
- Enable pause, CLK_HZ=4, rate 10 -> drop enable 3 cycles into a period for 10 cycles; count and divider frozen, no tick; after re-enable, tick arrives after the remaining 5 cycles.
- Clear/load priority: assert clear and load (load_val=A) together mid-period -> count=0, no tick. Next cycle load alone with load_val=A -> count=A, no tick; next step (up) gives count=B after a full period.
- Reset mid-operation, count=7 mid-period, pulse reset 1 cycle with enable=1 -> count=0, tick=0, wrap=0 next cycle; a full period elapses before count=1.

Source files
------------

// File: rtl/hex_rate_counter.sv
// Hex digit source for the 7-segment decoder: steps 0..F up or down at a
// switch-selected rate divided down from the board clock.
module hex_rate_counter #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned DIV_WIDTH = 28
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    input  logic       up_down,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       tick,
    output logic       wrap
);

    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] reload_c;
    logic [1:0]           rate_q;
    logic [3:0]           next_count_c;
    logic                 step_wrap_c;

    // Divider reload for the currently selected rate; a step takes reload+1 enabled cycles.
    always_comb begin
        reload_c = '0;
        case (rate_sel)
            2'b00:   reload_c = '0;
            2'b01:   reload_c = DIV_WIDTH'(CLK_HZ - 1);
            2'b10:   reload_c = DIV_WIDTH'(2 * CLK_HZ - 1);
            default: reload_c = DIV_WIDTH'(4 * CLK_HZ - 1);
        endcase
    end

    always_comb begin
        next_count_c = count;
        step_wrap_c  = 1'b0;
        if (up_down) begin
            next_count_c = count + 4'd1;
            step_wrap_c  = (count == 4'hF);
        end else begin
            next_count_c = count - 4'd1;
            step_wrap_c  = (count == 4'h0);
        end
    end

    // Priority: reset > clear > load > rate change > step > countdown/hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= 4'h0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            divider <= reload_c;
            rate_q  <= rate_sel;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clear) begin
                count   <= 4'h0;
                divider <= reload_c;
                rate_q  <= rate_sel;
            end else if (load) begin
                count   <= load_val;
                divider <= reload_c;
                rate_q  <= rate_sel;
            end else if (rate_sel != rate_q) begin
                divider <= reload_c;
                rate_q  <= rate_sel;
            end else if (enable) begin
                if (divider == '0) begin
                    count   <= next_count_c;
                    divider <= reload_c;
                    tick    <= 1'b1;
                    wrap    <= step_wrap_c;
                end else begin
                    divider <= divider - DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_rate_counter.sv
// Scoreboard bench for hex_rate_counter: stimulus queues per-cycle expectations,
// a negedge monitor compares them and flags any tick/wrap outside them.
module tb_hex_rate_counter;

    localparam int unsigned CLK_HZ  = 4;
    localparam int          END_CYC = 156;

    typedef struct packed {
        int         cyc;
        logic [3:0] cnt;
        logic       t;
        logic       w;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] rate_sel;
    logic       up_down;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tick;
    logic       wrap;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    hex_rate_counter #(.CLK_HZ(CLK_HZ), .DIV_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .rate_sel(rate_sel),
        .up_down(up_down), .clear(clear), .load(load), .load_val(load_val),
        .count(count), .tick(tick), .wrap(wrap)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: state after edge number cyc is sampled on the following negedge.
    always @(negedge clock) begin
        if (cyc > 0 && cyc <= END_CYC) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                exp_t m;
                m = sb.pop_front();
                n_checks++;
                $display("FAIL missed_expect cyc=%0d never compared (now %0d)", m.cyc, cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if (count === e.cnt && tick === e.t && wrap === e.w)
                    n_pass++;
                else
                    $display("FAIL expect_cyc%0d: got count=%h tick=%b wrap=%b, want count=%h tick=%b wrap=%b",
                             cyc, count, tick, wrap, e.cnt, e.t, e.w);
            end else begin
                n_checks++;
                if (tick === 1'b0 && wrap === 1'b0)
                    n_pass++;
                else
                    $display("FAIL quiet_cyc%0d: got tick=%b wrap=%b, want tick=0 wrap=0", cyc, tick, wrap);
            end
            if (cyc == END_CYC) begin
                n_checks++;
                if (sb.size() == 0)
                    n_pass++;
                else
                    $display("FAIL leftover: got %0d unchecked entries, want 0", sb.size());
            end
        end
    end

    task automatic expect_at(input int c, input logic [3:0] cnt, input logic t, input logic w);
        exp_t e;
        e.cyc = c; e.cnt = cnt; e.t = t; e.w = w;
        sb.push_back(e);
    endtask

    // Return just after edge c has updated the DUT, so new inputs apply from edge c+1.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; rate_sel = 2'b01; up_down = 1'b1;
        clear = 1'b0; load = 1'b0; load_val = 4'h0;

        // Reset held two edges, then 1 Hz stepping every 4 cycles.
        expect_at(1, 4'h0, 1'b0, 1'b0);
        expect_at(2, 4'h0, 1'b0, 1'b0);
        expect_at(6, 4'h1, 1'b1, 1'b0);
        expect_at(10, 4'h2, 1'b1, 1'b0);
        expect_at(14, 4'h3, 1'b1, 1'b0);
        goto(2);
        reset = 1'b0;

        // Rate 00: step every cycle, wrap F->0 twice, then one down-wrap 0->F.
        goto(14);
        rate_sel = 2'b00;
        expect_at(15, 4'h3, 1'b0, 1'b0);
        for (int k = 16; k <= 44; k++)
            expect_at(k, 4'((k - 12) % 16), 1'b1, ((k - 12) % 16) == 0);
        expect_at(45, 4'hF, 1'b1, 1'b1);
        expect_at(46, 4'hE, 1'b1, 1'b0);
        goto(44);
        up_down = 1'b0;
        goto(46);
        rate_sel = 2'b01;
        expect_at(47, 4'hE, 1'b0, 1'b0);
        expect_at(51, 4'hD, 1'b1, 1'b0);

        // Switch 01 -> 11 two cycles after a step: next ticks every 16 from the change edge.
        goto(51);
        up_down = 1'b1;
        goto(52);
        rate_sel = 2'b11;
        expect_at(53, 4'hD, 1'b0, 1'b0);
        expect_at(69, 4'hE, 1'b1, 1'b0);
        expect_at(85, 4'hF, 1'b1, 1'b0);
        expect_at(101, 4'h0, 1'b1, 1'b1);

        // Rate 10, pause 10 cycles 3 cycles into a period; 5 cycles remain after resume.
        goto(101);
        rate_sel = 2'b10;
        expect_at(102, 4'h0, 1'b0, 1'b0);
        expect_at(110, 4'h1, 1'b1, 1'b0);
        expect_at(118, 4'h1, 1'b0, 1'b0);
        expect_at(128, 4'h2, 1'b1, 1'b0);
        goto(113);
        enable = 1'b0;
        goto(123);
        enable = 1'b1;

        // Clear beats load; then load alone; next step a full period later.
        goto(130);
        clear = 1'b1; load = 1'b1; load_val = 4'hA;
        expect_at(131, 4'h0, 1'b0, 1'b0);
        expect_at(132, 4'hA, 1'b0, 1'b0);
        expect_at(140, 4'hB, 1'b1, 1'b0);
        goto(131);
        clear = 1'b0;
        goto(132);
        load = 1'b0;

        // Reset mid-period with count=7; full period before the next step.
        goto(140);
        load = 1'b1; load_val = 4'h7;
        expect_at(141, 4'h7, 1'b0, 1'b0);
        expect_at(144, 4'h0, 1'b0, 1'b0);
        expect_at(152, 4'h1, 1'b1, 1'b0);
        goto(141);
        load = 1'b0;
        goto(143);
        reset = 1'b1;
        goto(144);
        reset = 1'b0;

        goto(END_CYC + 1);
        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
